// File: rtl/mux_scanner.sv
// Time-division scanner for a 4:1 mux: steps the select lines through a..d,
// samples the mux output after a settle delay and publishes 4-bit frames.
module mux_scanner #(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       y,
    output logic       s1,
    output logic       s0,
    output logic [3:0] frame,
    output logic       frame_valid,
    output logic       busy
);
    localparam int CW = (DWELL <= 2) ? 1 : $clog2(DWELL);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(SETTLE);
    localparam logic [CW-1:0] LAST      = CW'(DWELL - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sel, sel_nxt;
    logic [CW-1:0] dcnt, dcnt_nxt;
    logic [3:0]    shadow, shadow_nxt;
    logic [3:0]    frame_nxt;
    logic          fv_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = SCAN;
            SCAN:    if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next-state; anything other than an active scan edge parks the
    // sequencer at channel a with an empty shadow, so aborts leave no residue.
    always_comb begin
        sel_nxt    = sel;
        dcnt_nxt   = dcnt;
        shadow_nxt = shadow;
        frame_nxt  = frame;
        fv_nxt     = 1'b0;
        if (state == SCAN && en) begin
            if (dcnt == SAMPLE_AT) shadow_nxt[sel] = y;
            if (dcnt == LAST) begin
                dcnt_nxt = '0;
                sel_nxt  = sel + 2'd1;
                if (sel == 2'b11) begin
                    // shadow_nxt so a coincident channel-d sample lands in this frame
                    frame_nxt = shadow_nxt;
                    fv_nxt    = 1'b1;
                end
            end else begin
                dcnt_nxt = dcnt + 1'b1;
            end
        end else begin
            sel_nxt    = 2'b00;
            dcnt_nxt   = '0;
            shadow_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= 2'b00;
            dcnt        <= '0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            sel         <= sel_nxt;
            dcnt        <= dcnt_nxt;
            shadow      <= shadow_nxt;
            frame       <= frame_nxt;
            frame_valid <= fv_nxt;
        end
    end

    always_comb begin
        busy = (state == SCAN);
        s1   = sel[1];
        s0   = sel[0];
    end
endmodule
